sdp_ram_sync_clr: RTL

Parametrised single-clock simple dual-port RAM: one write port (A) with per-byte write enables, one registered read port (B) with write-first collision forwarding. A built-in clear sequencer zeroes the whole array after reset and on request. It is the next-generation buffer RAM for datapath blocks: width and depth come from parameters rather than global defines, and read data carries a valid flag.

---
 rtl/sdp_ram_sync_clr.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdp_ram_sync_clr.sv
// Simple dual-port RAM (byte-write port A, registered read port B) with a clear sweep after reset / on request.
// Optional macro RAM_OUT_REG_EN adds a second output register stage (read latency 2).
module sdp_ram_sync_clr #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 256,
  localparam int ADDR  = $clog2(DEPTH),
  localparam int NBYTE = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              ena,
  input  logic [NBYTE-1:0]  wea,
  input  logic [ADDR-1:0]   addra,
  input  logic [WIDTH-1:0]  dina,
  input  logic              enb,
  input  logic [ADDR-1:0]   addrb,
  output logic [WIDTH-1:0]  doutb,
  output logic              doutb_vld
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR:0]   DEPTH_W = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_A  = ADDR'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR-1:0]   ptr_r;
  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic              wr_ok_s;
  logic              rd_acc_s;
  logic              rd_ok_s;
  logic [WIDTH-1:0]  fwd_word_s;

`ifdef RAM_OUT_REG_EN
  logic [WIDTH-1:0]  s1_data_r;
  logic              s1_vld_r;
`endif

  // Port qualification and write-first byte forwarding for the read word.
  always_comb begin
    wr_ok_s    = (state_r == ST_RUN) && ena && ({1'b0, addra} < DEPTH_W);
    rd_acc_s   = (state_r == ST_RUN) && enb && !clr_req;
    rd_ok_s    = ({1'b0, addrb} < DEPTH_W);
    fwd_word_s = {WIDTH{1'b0}};
    if (rd_ok_s) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (wr_ok_s && wea[i] && (addra == addrb)) begin
          fwd_word_s[8*i +: 8] = dina[8*i +: 8];
        end else begin
          fwd_word_s[8*i +: 8] = mem_r[addrb][8*i +: 8];
        end
      end
    end else begin
      fwd_word_s = {WIDTH{1'b0}};
    end
  end

  // Array storage: the sweep owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= {WIDTH{1'b0}};
    end else if (wr_ok_s) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (wea[i]) begin
          mem_r[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  // Clear/run sequencer and read output pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      ptr_r     <= {ADDR{1'b0}};
      busy      <= 1'b1;
      doutb     <= {WIDTH{1'b0}};
      doutb_vld <= 1'b0;
`ifdef RAM_OUT_REG_EN
      s1_data_r <= {WIDTH{1'b0}};
      s1_vld_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (ptr_r == LAST_A) begin
            state_r <= ST_RUN;
            busy    <= 1'b0;
            ptr_r   <= {ADDR{1'b0}};
          end else begin
            ptr_r   <= ptr_r + ADDR'(1);
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state_r <= ST_CLEAR;
            busy    <= 1'b1;
            ptr_r   <= {ADDR{1'b0}};
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          busy    <= 1'b1;
          ptr_r   <= {ADDR{1'b0}};
        end
      endcase

`ifdef RAM_OUT_REG_EN
      if (rd_acc_s) begin
        s1_data_r <= fwd_word_s;
        s1_vld_r  <= 1'b1;
      end else begin
        s1_vld_r  <= 1'b0;
      end
      // Second stage only delivers while the sequencer is running.
      if (s1_vld_r && !busy) begin
        doutb     <= s1_data_r;
        doutb_vld <= 1'b1;
      end else begin
        doutb_vld <= 1'b0;
      end
`else
      if (rd_acc_s) begin
        doutb     <= fwd_word_s;
        doutb_vld <= 1'b1;
      end else begin
        doutb_vld <= 1'b0;
      end
`endif
    end
  end

endmodule
